character_mover: RTL and testbench

CHARACTER_MOVER -- requirements
Module: character_mover

---
 rtl/character_mover.sv | 201 ++++++++++++++++++++
 tb/tb_character_mover.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/character_mover.sv
// Platformer character motion: a divided movement tick walks the character box
// left/right and runs a grounded/rising/falling vertical state machine against a tile map.
module character_mover #(
  parameter int BDR             = 0,
  parameter int SKY             = 1,
  parameter int BLK             = 2,
  parameter int GND             = 3,
  parameter int TKN             = 4,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int ROWS            = 12,
  parameter int COLS            = 17,
  parameter int TICK_DIVIDE     = 833333,
  parameter int WALK_STEP       = 1,
  parameter int RISE_STEP       = 2,
  parameter int FALL_STEP       = 2,
  parameter int JUMP_TICKS      = 60,
  parameter int START_X         = 40,
  parameter int START_Y         = 398
) (
  input  logic                             vga_clock,
  input  logic                             reset,
  input  logic                             left,
  input  logic                             right,
  input  logic                             jump,
  input  logic [ROWS-1:0][COLS-1:0][7:0]   background,
  output logic signed [31:0]               mario_x,
  output logic signed [31:0]               mario_y,
  output logic [1:0]                       move_state,
  output logic                             tick
);

  localparam int CNT_W = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
  localparam int JW    = $clog2(JUMP_TICKS + 1);
  localparam int RB    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CB    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW    = CHARACTER_WIDTH;
  localparam int BW    = BLOCK_WIDTH;
  localparam int MID   = CHARACTER_WIDTH / 2;

  localparam logic [1:0] ST_GROUNDED = 2'd0;
  localparam logic [1:0] ST_RISING   = 2'd1;
  localparam logic [1:0] ST_FALLING  = 2'd2;

  typedef logic [ROWS-1:0][COLS-1:0][7:0] map_t;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               jump_prev_q;
  logic               pending_q, pending_d;
  logic               rise_s;
  logic signed [31:0] x_q, x_d, y_q, y_d;
  logic signed [31:0] nx_s, ny_s;
  logic [1:0]         state_q, state_d;
  logic [JW-1:0]      juice_q, juice_d;

  // Unknown tile codes are treated as solid so a corrupt map can never let the box escape.
  function automatic logic is_solid(input logic [7:0] code);
    logic s;
    if (code == 8'(SKY) || code == 8'(TKN)) begin
      s = 1'b0;
    end else if (code == 8'(BDR) || code == 8'(BLK) || code == 8'(GND)) begin
      s = 1'b1;
    end else begin
      s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic solid_at(input map_t m, input logic signed [31:0] px,
                                    input logic signed [31:0] py);
    logic s;
    if (px < 0 || py < 0 || px >= COLS * BW || py >= ROWS * BW) begin
      s = is_solid(8'(BDR));
    end else begin
      s = is_solid(m[RB'(py / BW)][CB'(px / BW)]);
    end
    return s;
  endfunction

  // Vertical edge at column px, probed at top, middle and bottom of the box.
  function automatic logic col_blocked(input map_t m, input logic signed [31:0] px,
                                       input logic signed [31:0] y);
    return solid_at(m, px, y) | solid_at(m, px, y + MID) | solid_at(m, px, y + CW - 1);
  endfunction

  function automatic logic row_blocked(input map_t m, input logic signed [31:0] x,
                                       input logic signed [31:0] py);
    return solid_at(m, x, py) | solid_at(m, x + MID, py) | solid_at(m, x + CW - 1, py);
  endfunction

  // State register: all sequential state, synchronous reset wins over any tick.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      cnt_q       <= {CNT_W{1'b0}};
      tick_q      <= 1'b0;
      jump_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      x_q         <= 32'(START_X);
      y_q         <= 32'(START_Y);
      state_q     <= ST_GROUNDED;
      juice_q     <= {JW{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      jump_prev_q <= jump;
      pending_q   <= pending_d;
      x_q         <= x_d;
      y_q         <= y_d;
      state_q     <= state_d;
      juice_q     <= juice_d;
    end
  end

  // Next-state logic: tick divider, jump edge capture and the per-tick motion update.
  always_comb begin
    cnt_d     = (cnt_q == CNT_W'(TICK_DIVIDE - 1)) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    tick_d    = (cnt_d == CNT_W'(TICK_DIVIDE - 1));
    rise_s    = jump & ~jump_prev_q;
    pending_d = tick_q ? 1'b0 : (pending_q | rise_s);
    x_d       = x_q;
    y_d       = y_q;
    state_d   = state_q;
    juice_d   = juice_q;
    nx_s      = x_q;
    ny_s      = y_q;

    if (tick_q) begin
      if (right && !left) begin
        nx_s = x_q + WALK_STEP;
        if (nx_s >= 0 && nx_s <= SCREEN_WIDTH - CW && !col_blocked(background, nx_s + CW - 1, y_q)) begin
          x_d = nx_s;
        end else begin
          x_d = x_q;
        end
      end else if (left && !right) begin
        nx_s = x_q - WALK_STEP;
        if (nx_s >= 0 && nx_s <= SCREEN_WIDTH - CW && !col_blocked(background, nx_s, y_q)) begin
          x_d = nx_s;
        end else begin
          x_d = x_q;
        end
      end else begin
        x_d = x_q;
      end

      case (state_q)
        ST_GROUNDED: begin
          if (pending_q | rise_s) begin
            state_d = ST_RISING;
            juice_d = JW'(JUMP_TICKS);
          end else if (!row_blocked(background, x_q, y_q + CW)) begin
            state_d = ST_FALLING;
          end else begin
            state_d = ST_GROUNDED;
          end
        end
        ST_RISING: begin
          if (!jump || juice_q == {JW{1'b0}} || y_q < RISE_STEP ||
              row_blocked(background, x_q, y_q - RISE_STEP)) begin
            state_d = ST_FALLING;
            juice_d = {JW{1'b0}};
          end else begin
            y_d     = y_q - RISE_STEP;
            juice_d = juice_q - JW'(1);
          end
        end
        ST_FALLING: begin
          ny_s = y_q + FALL_STEP;
          if (row_blocked(background, x_q, ny_s + CW - 1)) begin
            // Snap the box onto the top of the tile row that stopped it.
            y_d     = ((ny_s + CW - 1) / BW) * BW - CW;
            state_d = ST_GROUNDED;
          end else if (ny_s > SCREEN_HEIGHT - CW) begin
            y_d     = SCREEN_HEIGHT - CW;
            state_d = ST_GROUNDED;
          end else begin
            y_d = ny_s;
          end
        end
        default: begin
          state_d = ST_FALLING;
          juice_d = {JW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    mario_x    = x_q;
    mario_y    = y_q;
    move_state = state_q;
    tick       = tick_q;
  end

endmodule

// File: tb/tb_character_mover.sv
// Directed bench for character_mover with a short tick divider: walking, walls,
// full and short jumps, walking off a ledge onto the screen floor, and reset mid-jump.
module tb_character_mover;

  localparam int ROWS = 12;
  localparam int COLS = 17;

  logic                           clk = 1'b0;
  logic                           reset = 1'b0;
  logic                           left = 1'b0;
  logic                           right = 1'b0;
  logic                           jump = 1'b0;
  logic [ROWS-1:0][COLS-1:0][7:0] bg;
  logic signed [31:0]             mario_x, mario_y;
  logic [1:0]                     move_state;
  logic                           tick;

  int checks = 0;
  int errors = 0;

  character_mover #(
    .TICK_DIVIDE(4), .WALK_STEP(2), .RISE_STEP(4), .FALL_STEP(4), .JUMP_TICKS(10),
    .CHARACTER_WIDTH(42), .BLOCK_WIDTH(40)
  ) dut (
    .vga_clock (clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .jump      (jump),
    .background(bg),
    .mario_x   (mario_x),
    .mario_y   (mario_y),
    .move_state(move_state),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next tick cycle, then sample just after the edge that applies it.
  task automatic step_tick();
    int n = 0;
    while (n < 16) begin
      @(negedge clk);
      if (tick === 1'b1) break;
      n++;
    end
    chk("tick_seen", int'(tick), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey, input int es);
    chk({tag, "_x"}, mario_x, ex);
    chk({tag, "_y"}, mario_y, ey);
    chk({tag, "_state"}, int'(move_state), es);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == 0) bg[r][c] = 8'd0;
        else if (r == 11) bg[r][c] = 8'd3;
        else bg[r][c] = 8'd1;
      end
    end

    // Reset state
    do_reset();
    chk_pos("reset", 40, 398, 0);
    chk("reset_tick", int'(tick), 0);

    // Walk right five ticks
    right = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step_tick();
      chk_pos("walk_right", 40 + 2 * i, 398, 0);
    end
    chk("tick_pulse", int'(tick), 0);
    right = 1'b0;

    // Left wall at column 0, then both directions cancel
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_tick();
      chk_pos("wall_left", 40, 398, 0);
    end
    right = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_tick();
      chk_pos("both_dirs", 40, 398, 0);
    end
    left = 1'b0;
    right = 1'b0;

    // Full jump with the button held
    jump = 1'b1;
    step_tick();
    chk_pos("jump_start", 40, 398, 1);
    for (int k = 1; k <= 10; k++) begin
      step_tick();
      chk_pos("rising", 40, 398 - 4 * k, 1);
    end
    step_tick();
    chk_pos("apex", 40, 358, 2);
    for (int k = 1; k <= 10; k++) begin
      step_tick();
      chk_pos("falling", 40, 358 + 4 * k, 2);
    end
    step_tick();
    chk_pos("landed", 40, 398, 0);
    step_tick();
    chk_pos("held_no_rejump", 40, 398, 0);
    jump = 1'b0;
    step_tick();
    chk_pos("idle", 40, 398, 0);

    // Short jump released after three rising steps
    jump = 1'b1;
    step_tick();
    chk_pos("short_start", 40, 398, 1);
    for (int k = 1; k <= 3; k++) begin
      step_tick();
      chk_pos("short_rise", 40, 398 - 4 * k, 1);
    end
    jump = 1'b0;
    step_tick();
    chk_pos("short_apex", 40, 386, 2);
    for (int k = 1; k <= 3; k++) begin
      step_tick();
      chk_pos("short_fall", 40, 386 + 4 * k, 2);
    end
    step_tick();
    chk_pos("short_land", 40, 398, 0);

    // Reset coinciding with a tick while rising at y=370
    jump = 1'b1;
    step_tick();
    for (int k = 1; k <= 7; k++) step_tick();
    chk_pos("pre_reset", 40, 370, 1);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (tick === 1'b1) break;
    end
    chk("reset_on_tick_seen", int'(tick), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_pos("mid_rise_reset", 40, 398, 0);
    chk("mid_rise_reset_tick", int'(tick), 0);
    jump = 1'b0;

    // Walk off a ledge over a gap in the ground and land on the screen floor
    bg[11][2] = 8'd1;
    bg[11][3] = 8'd1;
    do_reset();
    right = 1'b1;
    for (int i = 1; i <= 20; i++) step_tick();
    chk_pos("at_ledge", 80, 398, 0);
    right = 1'b0;
    step_tick();
    chk_pos("ledge_fall", 80, 398, 2);
    for (int k = 1; k <= 10; k++) begin
      step_tick();
      chk_pos("gap_fall", 80, 398 + 4 * k, 2);
    end
    step_tick();
    chk_pos("floor_clamp", 80, 438, 0);
    step_tick();
    chk_pos("floor_rest", 80, 438, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
